// File: rtl/product_accumulator.sv
// Burst accumulator for unsigned products from the 12x12 multiplier stage.
// Sums a programmed number of products with saturation and returns one result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; no product or result handshakes
// ACC   | accepting one product per beat until remaining reaches zero
// DONE  | holding the result on acc_out until the downstream takes it
module product_accumulator #(
    parameter int PROD_W = 24,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  acc_out,
    input  logic              acc_ready,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               busy_q;
    logic [ACC_W:0]     sum;

    // One extra bit catches the carry out that triggers saturation.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = S_ACC;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACC: begin
                if (prod_valid) begin
                    if (sum[ACC_W]) begin
                        acc_d = ACC_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign prod_ready = (state_q == S_ACC);
    assign acc_valid  = (state_q == S_DONE);
    assign acc_out    = acc_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed scenarios plus randomized bursts
// checked against a saturating-sum reference computed from the burst contents.
module tb_product_accumulator;

    localparam int PROD_W = 24;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 8;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              prod_ready;
    logic              acc_valid;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_ready;
    logic              busy;
    logic              overflow;

    int tests_run = 0;
    int failed    = 0;

    logic [PROD_W-1:0] beats[$];

    product_accumulator #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .prod_valid(prod_valid),
        .prod      (prod),
        .prod_ready(prod_ready),
        .acc_valid (acc_valid),
        .acc_out   (acc_out),
        .acc_ready (acc_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one full burst over the contents of beats[], starting at a negedge.
    // stall_mode >= 0 inserts that many idle cycles between beats; < 0 is random 0..2.
    task automatic do_burst(input int stall_mode, input int ready_delay,
                            input bit spam, input string tag);
        longint exp_sum = 0;
        bit     exp_ovf = 1'b0;
        int     n = beats.size();
        int     i = 0;
        int     s;
        logic [ACC_W-1:0] exp_acc;
        foreach (beats[k]) begin
            exp_sum += longint'(beats[k]);
            if (exp_sum > ACC_MAX) begin
                exp_sum = ACC_MAX;
                exp_ovf = 1'b1;
            end
        end
        exp_acc = exp_sum[ACC_W-1:0];

        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = spam;
        len   = spam ? LEN_W'(7) : LEN_W'($urandom);

        tests_run++;
        if (busy !== 1'b1 || overflow !== 1'b0 || acc_out !== '0) begin
            failed++;
            $display("FAIL %s after_start got busy=%0b ovf=%0b acc=%0h exp busy=1 ovf=0 acc=0",
                     tag, busy, overflow, acc_out);
        end
        tests_run++;
        if (prod_ready !== (n != 0) || acc_valid !== (n == 0)) begin
            failed++;
            $display("FAIL %s start_handshake got prod_ready=%0b acc_valid=%0b exp %0b/%0b",
                     tag, prod_ready, acc_valid, (n != 0), (n == 0));
        end

        while (i < n) begin
            s = (stall_mode >= 0) ? ((i > 0) ? stall_mode : 0) : int'($urandom_range(0, 2));
            repeat (s) begin
                prod_valid = 1'b0;
                prod       = PROD_W'($urandom);
                @(negedge clk);
                tests_run++;
                if (prod_ready !== 1'b1 || acc_valid !== 1'b0) begin
                    failed++;
                    $display("FAIL %s stall got prod_ready=%0b acc_valid=%0b exp 1/0",
                             tag, prod_ready, acc_valid);
                end
            end
            prod_valid = 1'b1;
            prod       = beats[i];
            @(negedge clk);
            i++;
            if (i < n) begin
                tests_run++;
                if (prod_ready !== 1'b1 || acc_valid !== 1'b0) begin
                    failed++;
                    $display("FAIL %s mid_burst beat=%0d got prod_ready=%0b acc_valid=%0b exp 1/0",
                             tag, i, prod_ready, acc_valid);
                end
            end
        end
        prod_valid = 1'b0;

        tests_run++;
        if (acc_valid !== 1'b1 || prod_ready !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL %s done_flags got acc_valid=%0b prod_ready=%0b busy=%0b exp 1/0/1",
                     tag, acc_valid, prod_ready, busy);
        end
        tests_run++;
        if (acc_out !== exp_acc || overflow !== exp_ovf) begin
            failed++;
            $display("FAIL %s result got acc=%0h ovf=%0b exp acc=%0h ovf=%0b",
                     tag, acc_out, overflow, exp_acc, exp_ovf);
        end

        repeat (ready_delay) begin
            prod_valid = spam ? 1'b1 : 1'b0;
            prod       = PROD_W'($urandom);
            @(negedge clk);
            tests_run++;
            if (acc_valid !== 1'b1 || acc_out !== exp_acc || overflow !== exp_ovf) begin
                failed++;
                $display("FAIL %s hold got acc_valid=%0b acc=%0h ovf=%0b exp 1/%0h/%0b",
                         tag, acc_valid, acc_out, overflow, exp_acc, exp_ovf);
            end
        end

        prod_valid = 1'b0;
        start      = 1'b0;
        acc_ready  = 1'b1;
        @(negedge clk);
        acc_ready  = 1'b0;
        tests_run++;
        if (acc_valid !== 1'b0 || busy !== 1'b0 || prod_ready !== 1'b0) begin
            failed++;
            $display("FAIL %s after_xfer got acc_valid=%0b busy=%0b prod_ready=%0b exp 0/0/0",
                     tag, acc_valid, busy, prod_ready);
        end
        tests_run++;
        if (acc_out !== exp_acc || overflow !== exp_ovf) begin
            failed++;
            $display("FAIL %s retained got acc=%0h ovf=%0b exp acc=%0h ovf=%0b",
                     tag, acc_out, overflow, exp_acc, exp_ovf);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        prod_valid = 1'b0;
        prod       = '0;
        acc_ready  = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (prod_ready !== 1'b0 || acc_valid !== 1'b0 || acc_out !== '0 ||
            busy !== 1'b0 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL reset got pr=%0b av=%0b acc=%0h busy=%0b ovf=%0b exp all 0",
                     prod_ready, acc_valid, acc_out, busy, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || prod_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_release got busy=%0b prod_ready=%0b exp 0/0", busy, prod_ready);
        end
    endtask

    task automatic test_basic();
        beats = '{24'd3, 24'd5, 24'd7, 24'd9};
        do_burst(0, 0, 1'b0, "basic");
    endtask

    task automatic test_stall();
        beats = '{24'd100, 24'd200, 24'd300};
        do_burst(2, 1, 1'b0, "stall");
    endtask

    task automatic test_saturation();
        beats = '{24'hFFFFFF, 24'h000001};
        do_burst(0, 0, 1'b0, "saturate");
        beats = '{24'd5};
        do_burst(0, 0, 1'b0, "after_saturate");
        beats = '{24'h800000, 24'h800000, 24'd0, 24'd0};
        do_burst(0, 1, 1'b0, "saturate_stick");
    endtask

    task automatic test_len_zero();
        beats.delete();
        do_burst(0, 5, 1'b0, "len_zero");
    endtask

    task automatic test_start_ignored();
        beats = '{24'd11, 24'd22, 24'd33, 24'd44};
        do_burst(1, 3, 1'b1, "start_ignored");
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        len   = LEN_W'(4);
        @(negedge clk);
        start = 1'b0;
        prod_valid = 1'b1;
        prod = 24'd10;
        @(negedge clk);
        prod = 24'd20;
        @(negedge clk);
        prod = 24'd30;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (prod_ready !== 1'b0 || acc_valid !== 1'b0 || acc_out !== '0 ||
            busy !== 1'b0 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid got pr=%0b av=%0b acc=%0h busy=%0b ovf=%0b exp all 0",
                     prod_ready, acc_valid, acc_out, busy, overflow);
        end
        prod_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beats = '{24'd42};
        do_burst(0, 0, 1'b0, "after_reset_mid");
    endtask

    task automatic test_random();
        for (int b = 0; b < 12; b++) begin
            int  n   = $urandom_range(0, 12);
            bit  big = 1'($urandom_range(0, 1));
            beats.delete();
            for (int k = 0; k < n; k++) begin
                beats.push_back(big ? PROD_W'($urandom) : PROD_W'($urandom_range(0, 2000)));
            end
            do_burst(-1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        beats = '{24'd1, 24'd2};
        do_burst(0, 0, 1'b0, "b2b_first");
        beats = '{24'd1000, 24'd2000, 24'd3000};
        do_burst(0, 0, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
